id_stage_p: RTL and testbench
=============================

ID_STAGE_P -- requirements
Module: id_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter NREGS, default 32, architectural register count (32 = RV32I, 16 = RV32E).
REQ-003 SHALL have parameter BRANCH_IN_ID, default 1, which resolves branches/jumps in decode; when 0, o_branch_taken is tied 0.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports i_valid/i_instr/i_pc  in  1/32/XLEN  IF/ID payload.
REQ-007 SHALL have port o_ready  out  1  ID accepts the current payload this cycle.
REQ-008 SHALL have ports i_wb_wr/i_wb_rd/i_wb_data  in  1/5/XLEN  writeback port.
REQ-009 SHALL have ports i_ex_ready, i_ex_is_load, i_ex_rd  in  1/1/5  EX backpressure and load destination.
REQ-010 SHALL have port i_flush  in  1  squash from a later stage.
REQ-011 SHALL have ports o_valid, o_rs1_data, o_rs2_data, o_imm, o_rd, o_opcode, o_func3, o_alu_ctrl, o_pc  out  1/XLEN/XLEN/XLEN/5/7/3/4/XLEN  ID/EX register.
REQ-012 SHALL have ports o_branch_taken, o_branch_pc, o_illegal  out  1/XLEN/1  redirect and exception flags.

Function
REQ-013 Decode SHALL be combinational from i_instr; all o_* except o_ready SHALL be registered (one-cycle latency from acceptance).
REQ-014 Hazard SHALL be asserted when i_valid, i_ex_is_load, i_ex_rd!=0, and i_ex_rd equals a used rs1/rs2.
REQ-015 o_ready SHALL equal (!o_valid | i_ex_ready) & !hazard.
REQ-016 When o_ready & i_valid, the output register SHALL load the decoded payload with o_valid=1.
REQ-017 On hazard with (!o_valid | i_ex_ready), the block SHALL load a bubble (o_valid=0, other outputs hold).
REQ-018 When o_valid & !i_ex_ready, all outputs SHALL hold.
REQ-019 The register file SHALL hold NREGS x XLEN, x0 SHALL read 0, writes SHALL be ignored for rd=0, and a same-cycle WB write SHALL bypass to reads.
REQ-020 Immediates for I/S/B/U/J formats SHALL be sign-extended to XLEN; R-type SHALL give o_imm=0.
REQ-021 o_alu_ctrl SHALL follow the package encoding: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B (LUI); branches SHALL use SUB.
REQ-022 When BRANCH_IN_ID=1, the block SHALL compare BEQ/BNE/BLT/BGE/BLTU/BGEU on bypassed operands.
REQ-023 Branch target SHALL be pc+imm; JAL SHALL always be taken to pc+imm; JALR SHALL be taken to (rs1+imm)&~1; additions SHALL wrap modulo 2^XLEN.
REQ-024 o_branch_taken/o_branch_pc SHALL register with the branch instruction and be valid only while o_valid=1.
REQ-025 The cycle after o_branch_taken=1 with i_ex_ready, the incoming wrong-path payload SHALL be dropped (o_ready=1, bubble loaded).
REQ-026 i_flush SHALL take priority over everything except rst: o_valid<=0, o_branch_taken<=0, input dropped, regfile writes still performed.
REQ-027 o_illegal SHALL be set for an unknown opcode or any register index >= NREGS; the instruction SHALL still pass with o_valid=1.

Reset
REQ-028 On rst, o_valid, o_branch_taken, and o_illegal SHALL be 0; all data outputs and all registers SHALL be 0; o_ready SHALL be 0 during rst.
REQ-029 rst asserted mid-stall SHALL discard the pending instruction; no state SHALL survive.

Structure
REQ-030 Opcode constants, alu_ctrl encoding, and func3 branch codes SHALL reside in shared package dhrutv_pkg.
REQ-031 The register file SHALL be sub-module id_regfile (params XLEN, NREGS; two read ports, one write port with bypass).

Verification
REQ-032 WB x8=5, then 0x00840393 (addi x7,x8,8) -> o_valid=1, o_rd=7, o_rs1_data=5, o_imm=8, o_alu_ctrl=ADD.
REQ-033 0x00218333 (add x6,x3,x2) while WB writes x3=0x11 the same cycle -> o_rs1_data=0x11 (bypass).
REQ-034 Same add with i_ex_is_load=1, i_ex_rd=3 -> o_ready=0, bubble; i_ex_is_load drops -> issued next cycle.
REQ-035 0x18431663 (bne x6,x4) at pc=0x40, x6!=x4 -> o_branch_taken=1, o_branch_pc=0x1CC, next input squashed; x6==x4 -> not taken.
REQ-036 0x00828467 (jalr x8,8(x5)), x5=0x101 -> o_branch_pc=0x108; i_ex_ready=0 holds outputs; i_flush -> o_valid=0.
REQ-037 NREGS=16: add x20,x1,x2 -> o_illegal=1; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/dhrutv_pkg.sv
// Shared decode constants for the dhrutv core: opcodes, ALU control encoding and branch func3
// codes.
package dhrutv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   // alt selects SUB for func3=000 and SRA for func3=101 (instr[30]).
   function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: two combinational read ports, one write port, x0 hardwired to
// zero and same-cycle write-to-read bypass.
module id_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_wr,
   input  logic [4:0]      i_wr_addr,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic [4:0]      i_rd_addr1,
   input  logic [4:0]      i_rd_addr2,
   output logic [XLEN-1:0] o_rd_data1,
   output logic [XLEN-1:0] o_rd_data2
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [XLEN-1:0] r_mem [NREGS];
   logic            w_wr_en;
   logic            w_ok1;
   logic            w_ok2;

   assign w_wr_en = i_wr && (i_wr_addr != 5'd0) && (32'(i_wr_addr) < NREGS);
   assign w_ok1   = (i_rd_addr1 != 5'd0) && (32'(i_rd_addr1) < NREGS);
   assign w_ok2   = (i_rd_addr2 != 5'd0) && (32'(i_rd_addr2) < NREGS);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data1 = '0;
      if (w_ok1) begin
         o_rd_data1 = (w_wr_en && (i_wr_addr == i_rd_addr1)) ? i_wr_data
                                                             : r_mem[i_rd_addr1[AW-1:0]];
      end
   end

   always_comb begin
      o_rd_data2 = '0;
      if (w_ok2) begin
         o_rd_data2 = (w_wr_en && (i_wr_addr == i_rd_addr2)) ? i_wr_data
                                                             : r_mem[i_rd_addr2[AW-1:0]];
      end
   end

endmodule

// File: rtl/id_stage_p.sv
// Instruction decode stage: field decode, register read, load-use interlock, optional branch
// resolution, and the ID/EX pipeline register.
module id_stage_p
   import dhrutv_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NREGS        = 32,
   parameter int unsigned BRANCH_IN_ID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_ready,
   input  logic            i_wb_wr,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   input  logic            i_ex_ready,
   input  logic            i_ex_is_load,
   input  logic [4:0]      i_ex_rd,
   input  logic            i_flush,
   output logic            o_valid,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [XLEN-1:0] o_imm,
   output logic [4:0]      o_rd,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_func3,
   output logic [3:0]      o_alu_ctrl,
   output logic [XLEN-1:0] o_pc,
   output logic            o_branch_taken,
   output logic [XLEN-1:0] o_branch_pc,
   output logic            o_illegal
);

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [2:0]      w_f3;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic            w_use_rd;
   logic            w_known;
   logic            w_is_br;
   logic            w_is_jal;
   logic            w_is_jalr;
   imm_fmt_e        w_fmt;
   alu_ctrl_e       w_alu;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;
   logic [XLEN-1:0] w_pc_tgt;
   logic [XLEN-1:0] w_jalr_sum;
   logic            w_cond;
   logic            w_taken;
   logic [XLEN-1:0] w_bpc;
   logic            w_illegal;
   logic            w_hazard;
   logic            w_ex_free;
   logic            w_squash;
   logic            w_load;
   logic            w_bubble;

   logic            r_valid;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rd;
   logic [6:0]      r_opcode;
   logic [2:0]      r_func3;
   logic [3:0]      r_alu_ctrl;
   logic [XLEN-1:0] r_pc;
   logic            r_branch_taken;
   logic [XLEN-1:0] r_branch_pc;
   logic            r_illegal;

   assign w_opcode = i_instr[6:0];
   assign w_rd     = i_instr[11:7];
   assign w_f3     = i_instr[14:12];
   assign w_rs1    = i_instr[19:15];
   assign w_rs2    = i_instr[24:20];

   always_comb begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      w_known   = 1'b1;
      w_is_br   = 1'b0;
      w_is_jal  = 1'b0;
      w_is_jalr = 1'b0;
      w_fmt     = IMM_NONE;
      w_alu     = ALU_ADD;
      case (w_opcode)
         OPC_LUI: begin
            w_use_rd = 1'b1;
            w_fmt    = IMM_U;
            w_alu    = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            w_use_rd = 1'b1;
            w_fmt    = IMM_U;
         end
         OPC_JAL: begin
            w_use_rd = 1'b1;
            w_fmt    = IMM_J;
            w_is_jal = 1'b1;
         end
         OPC_JALR: begin
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
            w_fmt     = IMM_I;
            w_is_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_fmt     = IMM_B;
            w_alu     = ALU_SUB;
            w_is_br   = 1'b1;
         end
         OPC_LOAD: begin
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
            w_fmt     = IMM_I;
         end
         OPC_STORE: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_fmt     = IMM_S;
         end
         OPC_IMM: begin
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
            w_fmt     = IMM_I;
            // addi has no subtract form; only the shift-right pair uses instr[30]
            w_alu     = alu_from_f3(w_f3, i_instr[30] && (w_f3 == 3'b101));
         end
         OPC_REG: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_use_rd  = 1'b1;
            w_alu     = alu_from_f3(w_f3, i_instr[30]);
         end
         default: w_known = 1'b0;
      endcase
   end

   always_comb begin
      case (w_fmt)
         IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instr[31:12], 12'h000};
         IMM_J:   w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21],
                             1'b0};
         default: w_imm32 = 32'h0;
      endcase
   end

   assign w_imm = XLEN'($signed(w_imm32));

   id_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .i_wr       (i_wb_wr),
      .i_wr_addr  (i_wb_rd),
      .i_wr_data  (i_wb_data),
      .i_rd_addr1 (w_rs1),
      .i_rd_addr2 (w_rs2),
      .o_rd_data1 (w_rs1_data),
      .o_rd_data2 (w_rs2_data)
   );

   always_comb begin
      case (w_f3)
         F3_BEQ:  w_cond = (w_rs1_data == w_rs2_data);
         F3_BNE:  w_cond = (w_rs1_data != w_rs2_data);
         F3_BLT:  w_cond = ($signed(w_rs1_data) < $signed(w_rs2_data));
         F3_BGE:  w_cond = ($signed(w_rs1_data) >= $signed(w_rs2_data));
         F3_BLTU: w_cond = (w_rs1_data < w_rs2_data);
         F3_BGEU: w_cond = (w_rs1_data >= w_rs2_data);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_pc_tgt   = i_pc + w_imm;
   assign w_jalr_sum = w_rs1_data + w_imm;
   assign w_bpc      = w_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_pc_tgt;
   assign w_taken    = (BRANCH_IN_ID != 0) && (w_is_jal || w_is_jalr || (w_is_br && w_cond));

   assign w_illegal = !w_known
                    || (w_use_rs1 && (32'(w_rs1) >= NREGS))
                    || (w_use_rs2 && (32'(w_rs2) >= NREGS))
                    || (w_use_rd  && (32'(w_rd)  >= NREGS));

   assign w_hazard = i_valid && i_ex_is_load && (i_ex_rd != 5'd0)
                   && ((w_use_rs1 && (w_rs1 == i_ex_rd)) || (w_use_rs2 && (w_rs2 == i_ex_rd)));

   // A taken branch leaving for EX means the payload now at the input is wrong-path.
   assign w_ex_free = !r_valid || i_ex_ready;
   assign w_squash  = r_valid && r_branch_taken && i_ex_ready;
   assign w_load    = w_ex_free && i_valid && !w_hazard && !w_squash && !i_flush;
   assign w_bubble  = i_flush || w_squash || (w_ex_free && !w_load);

   assign o_ready = !rst && ((w_ex_free && !w_hazard) || w_squash);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid        <= 1'b0;
         r_rs1_data     <= '0;
         r_rs2_data     <= '0;
         r_imm          <= '0;
         r_rd           <= '0;
         r_opcode       <= '0;
         r_func3        <= '0;
         r_alu_ctrl     <= '0;
         r_pc           <= '0;
         r_branch_taken <= 1'b0;
         r_branch_pc    <= '0;
         r_illegal      <= 1'b0;
      end else if (w_bubble) begin
         r_valid        <= 1'b0;
         r_branch_taken <= 1'b0;
      end else if (w_load) begin
         r_valid        <= 1'b1;
         r_rs1_data     <= w_rs1_data;
         r_rs2_data     <= w_rs2_data;
         r_imm          <= w_imm;
         r_rd           <= w_use_rd ? w_rd : 5'd0;
         r_opcode       <= w_opcode;
         r_func3        <= w_f3;
         r_alu_ctrl     <= w_alu;
         r_pc           <= i_pc;
         r_branch_taken <= w_taken;
         r_branch_pc    <= w_bpc;
         r_illegal      <= w_illegal;
      end
   end

   assign o_valid        = r_valid;
   assign o_rs1_data     = r_rs1_data;
   assign o_rs2_data     = r_rs2_data;
   assign o_imm          = r_imm;
   assign o_rd           = r_rd;
   assign o_opcode       = r_opcode;
   assign o_func3        = r_func3;
   assign o_alu_ctrl     = r_alu_ctrl;
   assign o_pc           = r_pc;
   assign o_branch_taken = r_branch_taken;
   assign o_branch_pc    = r_branch_pc;
   assign o_illegal      = r_illegal;

endmodule

// File: tb/tb_id_stage_p.sv
// Scoreboard bench for id_stage_p: directed scenarios then randomized traffic checked against a
// behavioural decode/pipeline model; a second instance with NREGS=16 covers the RV32E check.
module tb_id_stage_p;
   import dhrutv_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_valid = 1'b0;
   logic [31:0]     i_instr = '0;
   logic [XLEN-1:0] i_pc = '0;
   logic            i_wb_wr = 1'b0;
   logic [4:0]      i_wb_rd = '0;
   logic [XLEN-1:0] i_wb_data = '0;
   logic            i_ex_ready = 1'b1;
   logic            i_ex_is_load = 1'b0;
   logic [4:0]      i_ex_rd = '0;
   logic            i_flush = 1'b0;

   logic o_ready, o_valid, o_branch_taken, o_illegal;
   logic [XLEN-1:0] o_rs1_data, o_rs2_data, o_imm, o_pc, o_branch_pc;
   logic [4:0] o_rd;
   logic [6:0] o_opcode;
   logic [2:0] o_func3;
   logic [3:0] o_alu_ctrl;

   logic b_ready, b_valid, b_branch_taken, b_illegal;
   logic [XLEN-1:0] b_rs1_data, b_rs2_data, b_imm, b_pc, b_branch_pc;
   logic [4:0] b_rd;
   logic [6:0] b_opcode;
   logic [2:0] b_func3;
   logic [3:0] b_alu_ctrl;

   always #5 clk = ~clk;

   id_stage_p #(.XLEN(XLEN), .NREGS(32), .BRANCH_IN_ID(1)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
      .o_ready(o_ready), .i_wb_wr(i_wb_wr), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .i_ex_ready(i_ex_ready), .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd),
      .i_flush(i_flush), .o_valid(o_valid), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
      .o_imm(o_imm), .o_rd(o_rd), .o_opcode(o_opcode), .o_func3(o_func3),
      .o_alu_ctrl(o_alu_ctrl), .o_pc(o_pc), .o_branch_taken(o_branch_taken),
      .o_branch_pc(o_branch_pc), .o_illegal(o_illegal)
   );

   id_stage_p #(.XLEN(XLEN), .NREGS(16), .BRANCH_IN_ID(1)) dut16 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
      .o_ready(b_ready), .i_wb_wr(i_wb_wr), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .i_ex_ready(i_ex_ready), .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd),
      .i_flush(i_flush), .o_valid(b_valid), .o_rs1_data(b_rs1_data), .o_rs2_data(b_rs2_data),
      .o_imm(b_imm), .o_rd(b_rd), .o_opcode(b_opcode), .o_func3(b_func3),
      .o_alu_ctrl(b_alu_ctrl), .o_pc(b_pc), .o_branch_taken(b_branch_taken),
      .o_branch_pc(b_branch_pc), .o_illegal(b_illegal)
   );

   typedef struct {
      logic [31:0] rs1, rs2, imm, pc, bpc;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic        taken, ill;
   } exp_t;

   exp_t        q[$];
   exp_t        last_e;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_rf [32];
   logic        m_valid = 1'b0;
   logic        m_taken = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic is_known(input logic [6:0] op);
      return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                        OPC_IMM, OPC_REG};
   endfunction
   function automatic logic reads_rs1(input logic [6:0] op);
      return op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_IMM, OPC_REG};
   endfunction
   function automatic logic reads_rs2(input logic [6:0] op);
      return op inside {OPC_BRANCH, OPC_STORE, OPC_REG};
   endfunction
   function automatic logic writes_rd(input logic [6:0] op);
      return op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_IMM, OPC_REG};
   endfunction

   function automatic logic [31:0] imm_of(input logic [31:0] ins);
      int v;
      v = 0;
      if (ins[6:0] inside {OPC_JALR, OPC_LOAD, OPC_IMM}) v = $signed(ins[31:20]);
      else if (ins[6:0] == OPC_STORE) v = $signed({ins[31:25], ins[11:7]});
      else if (ins[6:0] == OPC_BRANCH) v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      else if (ins[6:0] inside {OPC_LUI, OPC_AUIPC}) v = {ins[31:12], 12'h000};
      else if (ins[6:0] == OPC_JAL)
         v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      return v;
   endfunction

   function automatic logic [3:0] alu_of(input logic [31:0] ins);
      alu_ctrl_e tab [8];
      logic [2:0] f;
      tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      f = ins[14:12];
      if (ins[6:0] == OPC_LUI) return ALU_PASS_B;
      if (ins[6:0] == OPC_BRANCH) return ALU_SUB;
      if (ins[6:0] inside {OPC_IMM, OPC_REG}) begin
         if (ins[30] && f == 3'd5) return ALU_SRA;
         if (ins[30] && f == 3'd0 && ins[6:0] == OPC_REG) return ALU_SUB;
         return tab[f];
      end
      return ALU_ADD;
   endfunction

   function automatic logic [31:0] reg_read(input logic [4:0] idx, input logic wr,
                                            input logic [4:0] wrd, input logic [31:0] wd);
      if (idx == 5'd0) return 32'h0;
      if (wr && wrd == idx) return wd;
      return m_rf[idx];
   endfunction

   function automatic exp_t expect_of(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic wr, input logic [4:0] wrd,
                                      input logic [31:0] wd);
      exp_t e;
      logic [31:0] a, b;
      a = reg_read(ins[19:15], wr, wrd, wd);
      b = reg_read(ins[24:20], wr, wrd, wd);
      e.rs1 = a;
      e.rs2 = b;
      e.imm = imm_of(ins);
      e.pc = pc;
      e.rd = writes_rd(ins[6:0]) ? ins[11:7] : 5'd0;
      e.op = ins[6:0];
      e.f3 = ins[14:12];
      e.alu = alu_of(ins);
      e.ill = !is_known(ins[6:0]);
      e.taken = 1'b0;
      if (ins[6:0] inside {OPC_JAL, OPC_JALR}) e.taken = 1'b1;
      if (ins[6:0] == OPC_BRANCH) begin
         case (ins[14:12])
            3'd0: e.taken = (a == b);
            3'd1: e.taken = (a != b);
            3'd4: e.taken = ($signed(a) < $signed(b));
            3'd5: e.taken = ($signed(a) >= $signed(b));
            3'd6: e.taken = (a < b);
            3'd7: e.taken = (a >= b);
            default: e.taken = 1'b0;
         endcase
      end
      e.bpc = (ins[6:0] == OPC_JALR) ? ((a + e.imm) & 32'hFFFF_FFFE) : (pc + e.imm);
      return e;
   endfunction

   // One cycle: drive inputs, check o_ready, advance the model across the clock edge.
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic wr, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic exr, input logic ld, input logic [4:0] lrd, input logic fl);
      exp_t e;
      logic hz, free, sq;
      i_valid = v; i_instr = ins; i_pc = pc;
      i_wb_wr = wr; i_wb_rd = wrd; i_wb_data = wd;
      i_ex_ready = exr; i_ex_is_load = ld; i_ex_rd = lrd; i_flush = fl;
      e = expect_of(ins, pc, wr, wrd, wd);
      hz = v && ld && lrd != 5'd0 && ((reads_rs1(ins[6:0]) && ins[19:15] == lrd)
                                   || (reads_rs2(ins[6:0]) && ins[24:20] == lrd));
      free = !m_valid || exr;
      sq = m_valid && m_taken && exr;
      #2;
      check("o_ready", 64'(o_ready), 64'((free && !hz) || sq));
      @(posedge clk);
      if (fl || sq) begin
         m_valid = 1'b0; m_taken = 1'b0;
      end else if (free) begin
         if (v && !hz) begin
            m_valid = 1'b1; m_taken = e.taken; q.push_back(e);
         end else begin
            m_valid = 1'b0; m_taken = 1'b0;
         end
      end
      if (wr && wrd != 5'd0) m_rf[wrd] = wd;
      #1;
   endtask

   task automatic idle(input logic wr, input logic [4:0] wrd, input logic [31:0] wd);
      step(1'b0, 32'h0, 32'h0, wr, wrd, wd, 1'b1, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic exr);
      step(1'b1, ins, pc, 1'b0, 5'd0, 32'h0, exr, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         #2;
         check("o_ready_in_rst", 64'(o_ready), 64'h0);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_valid = 1'b0; m_taken = 1'b0;
      q.delete();
      rst = 1'b0;
      check("rst_valid", 64'(o_valid), 64'h0);
      check("rst_taken", 64'(o_branch_taken), 64'h0);
      check("rst_illegal", 64'(o_illegal), 64'h0);
      check("rst_data", 64'(o_rs1_data | o_rs2_data | o_imm | o_pc | o_branch_pc), 64'h0);
      check("rst_fields", 64'({o_rd, o_opcode, o_func3, o_alu_ctrl}), 64'h0);
      check("rst16_valid", 64'({b_valid, b_illegal, b_branch_taken}), 64'h0);
   endtask

   task automatic cmp_out(input exp_t e, input string tag);
      check({tag, "rs1_data"}, 64'(o_rs1_data), 64'(e.rs1));
      check({tag, "rs2_data"}, 64'(o_rs2_data), 64'(e.rs2));
      check({tag, "imm"}, 64'(o_imm), 64'(e.imm));
      check({tag, "rd"}, 64'(o_rd), 64'(e.rd));
      check({tag, "opcode"}, 64'(o_opcode), 64'(e.op));
      check({tag, "func3"}, 64'(o_func3), 64'(e.f3));
      check({tag, "alu_ctrl"}, 64'(o_alu_ctrl), 64'(e.alu));
      check({tag, "pc"}, 64'(o_pc), 64'(e.pc));
      check({tag, "branch_taken"}, 64'(o_branch_taken), 64'(e.taken));
      check({tag, "illegal"}, 64'(o_illegal), 64'(e.ill));
      if (e.taken) check({tag, "branch_pc"}, 64'(o_branch_pc), 64'(e.bpc));
   endtask

   // Monitor: a valid output is new if EX could take the previous one; otherwise it must hold.
   initial begin
      logic prev_free;
      prev_free = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_free = 1'b1;
         end else begin
            if (o_valid) begin
               if (prev_free) begin
                  if (q.size() == 0) begin
                     check("unexpected_valid", 64'(o_valid), 64'h0);
                  end else begin
                     last_e = q.pop_front();
                     cmp_out(last_e, "");
                  end
               end else begin
                  cmp_out(last_e, "hold_");
               end
            end else begin
               check("taken_without_valid", 64'(o_branch_taken), 64'h0);
            end
            prev_free = !o_valid || i_ex_ready;
         end
      end
   end

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [9];
      logic [2:0] brf [6];
      logic [31:0] ins;
      int k;
      ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_IMM,
              OPC_REG};
      brf = '{F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[11:7] = 5'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      if (k == 9) begin
         do ins[6:0] = 7'($urandom); while (is_known(ins[6:0]));
      end else begin
         ins[6:0] = ops[k];
         if (ins[6:0] == OPC_BRANCH) ins[14:12] = brf[$urandom_range(0, 5)];
         if (ins[6:0] == OPC_REG) ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'b0};
      end
      return ins;
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      do_reset(2);

      // addi x7,x8,8 after x8=5
      idle(1'b1, 5'd8, 32'd5);
      issue(32'h0084_0393, 32'h0, 1'b1);
      check("addi_valid", 64'(o_valid), 64'h1);
      check("addi_rd", 64'(o_rd), 64'd7);
      check("addi_rs1", 64'(o_rs1_data), 64'd5);
      check("addi_imm", 64'(o_imm), 64'd8);
      check("addi_alu", 64'(o_alu_ctrl), 64'(ALU_ADD));

      // add x6,x3,x2 with a same-cycle write of x3
      step(1'b1, 32'h0021_8333, 32'h4, 1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 5'd0, 1'b0);
      check("bypass_rs1", 64'(o_rs1_data), 64'h11);

      // load-use on x3: bubble, then issue when the load clears
      step(1'b1, 32'h0021_8333, 32'h8, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0);
      check("hazard_bubble", 64'(o_valid), 64'h0);
      issue(32'h0021_8333, 32'h8, 1'b1);
      check("hazard_issue", 64'(o_valid), 64'h1);

      // bne x6,x4 taken, wrong-path squash, then not taken
      idle(1'b1, 5'd6, 32'd1);
      idle(1'b1, 5'd4, 32'd2);
      issue(32'h1843_1663, 32'h40, 1'b1);
      check("bne_taken", 64'(o_branch_taken), 64'h1);
      check("bne_target", 64'(o_branch_pc), 64'h1CC);
      issue(32'h0084_0393, 32'h44, 1'b1);
      check("wrong_path_dropped", 64'(o_valid), 64'h0);
      idle(1'b1, 5'd6, 32'd2);
      issue(32'h1843_1663, 32'h40, 1'b1);
      check("bne_not_taken", 64'(o_branch_taken), 64'h0);

      // jalr x8,8(x5), stall hold, then flush
      idle(1'b1, 5'd5, 32'h101);
      issue(32'h0082_8467, 32'h80, 1'b1);
      check("jalr_target", 64'(o_branch_pc), 64'h108);
      issue(32'h0084_0393, 32'h84, 1'b0);
      check("stall_hold_valid", 64'(o_valid), 64'h1);
      check("stall_hold_target", 64'(o_branch_pc), 64'h108);
      step(1'b1, 32'h0084_0393, 32'h84, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
      check("flush_valid", 64'(o_valid), 64'h0);
      check("flush_taken", 64'(o_branch_taken), 64'h0);

      // add x20,x1,x2: illegal only with 16 registers
      issue(32'h0020_8A33, 32'h90, 1'b1);
      check("rv32e_valid", 64'(b_valid), 64'h1);
      check("rv32e_illegal", 64'(b_illegal), 64'h1);
      check("rv32i_legal", 64'(o_illegal), 64'h0);

      // reset in the middle of a stall
      issue(32'h0084_0393, 32'h94, 1'b1);
      issue(32'h0084_0393, 32'h98, 1'b0);
      do_reset(1);
      issue(32'h0084_0393, 32'h9C, 1'b1);
      check("post_rst_rs1", 64'(o_rs1_data), 64'h0);

      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 99) < 80), rand_instr(), {$urandom, 2'b00} ,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 99) < 75), 1'($urandom_range(0, 99) < 25),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 5));
      end
      for (int n = 0; n < 3; n++) idle(1'b0, 5'd0, 32'h0);
      check("scoreboard_drained", 64'(q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
